dcache_wb_buffer: RTL and testbench
===================================

Name: dcache_wb_buffer

Overview:
- Write-back (victim) buffer directly downstream of the data cache memory.
- Captures dirty lines evicted by the cache (evict enable, 32-bit address, 64-bit line) into a small FIFO.
- Drains the FIFO to main memory as BUS_STORE commands through the shared memory arbiter.
- Offers a combinational lookup port so a refill load never reads stale memory for a line still sitting in the buffer.

Parameters:
- DEPTH, 4, number of buffered lines; power of two, at least 2.
- TAG_W, 4, width of the memory response tag; 0 means not accepted.

Ports:
- clock  in  1  system clock, all state on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- evict_en  in  1  push request: one evicted dirty line this cycle.
- evict_addr  in  32  line address of the evicted line; bits [2:0] are 0.
- evict_data  in  64  evicted line data.
- lookup_en  in  1  refill lookup request.
- lookup_addr  in  32  lookup address; compared on bits [31:3].
- mem_grant  in  1  arbiter grants the memory bus to this block this cycle.
- mem2wb_response  in  TAG_W  memory accept tag; non-zero means the store was accepted.
- wb2mem_command  out  2  0=BUS_NONE, 1=BUS_LOAD (never driven), 2=BUS_STORE.
- wb2mem_addr  out  32  store address.
- wb2mem_data  out  64  store data.
- wb_full  out  1  count == DEPTH; the cache must not evict.
- wb_empty  out  1  count == 0.
- lookup_hit  out  1  lookup matched a buffered or incoming line.
- lookup_data  out  64  data of the youngest matching line; 0 when no hit.
- overflow_err  out  1  sticky: a push was dropped.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr[31:3], data[63:0]}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (reset==0, asynchronous, takes effect immediately):
  - pointers and count go to 0; state goes to IDLE; overflow_err goes to 0.
  - outputs: wb2mem_command=0, wb2mem_addr=0, wb2mem_data=0, wb_full=0, wb_empty=1.
  - lookup_hit and lookup_data reflect the empty buffer, so both are 0 unless the bypass path below hits.
  - Entries pending at reset are discarded and are never stored.
- Push:
  - A push occurs on a rising edge with evict_en=1 and (count<DEPTH or a pop on the same edge).
  - The entry is written at tail; tail increments.
- Pop:
  - A pop occurs on a rising edge with state==ISSUE, mem_grant=1 and mem2wb_response!=0.
  - The head entry is retired; head increments.
- Push and pop on the same edge: both happen and count is unchanged; this is legal even when full.
- Push when full with no pop on that edge: the entry is dropped, count is unchanged, and overflow_err is set to 1 from the next cycle until reset.
- FSM:
  - IDLE: wb2mem_command=BUS_NONE. Go to ISSUE on the edge where count becomes non-zero.
  - ISSUE:
    - With mem_grant=1: drive BUS_STORE, wb2mem_addr={head.addr,3'b000}, wb2mem_data=head.data.
    - With mem_grant=0: command=BUS_NONE and addr/data=0.
    - Stay in ISSUE until a pop leaves count==0 with no simultaneous push; then go to IDLE.
    - A rejected store (response==0) is retried with the same entry on every granted cycle.
- Latency: a line pushed at edge N is first presented as BUS_STORE in cycle N+1, provided the buffer was empty and mem_grant=1. Strict FIFO order is kept to memory.
- Lookup (combinational, only when lookup_en=1):
  - Match valid entries on addr[31:3], plus a bypass of the evict_addr input when evict_en=1 in the same cycle.
  - Priority: the bypass input wins, then the youngest entry (closest to tail).
  - An entry being popped this cycle still counts as valid and can hit.
  - With lookup_en=0: lookup_hit=0 and lookup_data=0.
- Duplicate addresses are allowed in the FIFO; both are stored in order, so the youngest ends up in memory last.
- wb_full and wb_empty are decoded from registered count and carry no combinational path from inputs.

Test Plan:
- Reset and single push: reset low then high; push addr 0x0000_1008, data 0xDEAD_BEEF_0000_0001 with mem_grant=1.
  - wb_empty 1→0 after the edge.
  - Next cycle: command=2, addr=0x1008.
  - response=3 pops the entry, then wb_empty=1 and command=0.
- Retry: mem_grant=1 with response=0 for 3 cycles, then 5.
  - The same store is held for 4 cycles.
  - It pops only on the 4th; no reordering.
- Fill and overflow: with mem_grant=0, push 4 lines (0x100, 0x108, 0x110, 0x118).
  - wb_full=1.
  - A 5th push (0x120) is dropped and overflow_err=1.
  - Drained addresses are 0x100, 0x108, 0x110, 0x118 in order.
- Full with simultaneous push and pop: full buffer, granted accept plus push of 0x200 on the same edge.
  - count stays 4 and overflow_err stays 0.
  - 0x200 drains last.
- Lookup priority: buffer holds 0x300/data A, then 0x300/data B.
  - lookup 0x304 → hit, data B.
  - With evict_en for 0x300/data C in the same cycle → data C.
  - lookup 0x400 → hit=0, data=0.
- Reset mid-drain: pull reset low while a store is in ISSUE.
  - command=0 immediately, without waiting for a clock edge.
  - After release: wb_empty=1 and no stale store is issued.

Source files
------------

// File: rtl/dcache_wb_buffer.sv
// Victim buffer between the data cache and main memory: queues evicted dirty lines,
// drains them in order as BUS_STORE commands and forwards buffered data to refill lookups.
module dcache_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             evict_en,
    input  logic [31:0]      evict_addr,
    input  logic [63:0]      evict_data,
    input  logic             lookup_en,
    input  logic [31:0]      lookup_addr,
    input  logic             mem_grant,
    input  logic [TAG_W-1:0] mem2wb_response,
    output logic [1:0]       wb2mem_command,
    output logic [31:0]      wb2mem_addr,
    output logic [63:0]      wb2mem_data,
    output logic             wb_full,
    output logic             wb_empty,
    output logic             lookup_hit,
    output logic [63:0]      lookup_data,
    output logic             overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    logic [28:0]      line_q [DEPTH];
    logic [63:0]      data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [PTR_W-1:0] idx;

    // Address offset bits carry no information for a line-granular buffer.
    logic unused_low_bits;
    assign unused_low_bits = ^{evict_addr[2:0], lookup_addr[2:0]};

    // A full buffer still accepts a push when the head retires on the same edge.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        pop     = (state_q == ISSUE) && mem_grant && (mem2wb_response != '0);
        push    = evict_en && (!full || pop);
        drop    = evict_en && full && !pop;
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d   = ovf_q | drop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            line_q[tail_q] <= evict_addr[31:3];
            data_q[tail_q] <= evict_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb2mem_command = BUS_NONE;
        wb2mem_addr    = '0;
        wb2mem_data    = '0;
        if (state_q == ISSUE && mem_grant) begin
            wb2mem_command = BUS_STORE;
            wb2mem_addr    = {line_q[head_q], 3'b000};
            wb2mem_data    = data_q[head_q];
        end
    end

    // Walk oldest to youngest so the youngest match wins; the incoming eviction overrides all.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = head_q;
        if (lookup_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (line_q[idx] == lookup_addr[31:3])) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data_q[idx];
                end
            end
            if (evict_en && (evict_addr[31:3] == lookup_addr[31:3])) begin
                lookup_hit  = 1'b1;
                lookup_data = evict_data;
            end
        end
    end

    assign wb_full      = full;
    assign wb_empty     = (count_q == '0);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus a randomized run against a queue model.
module tb_dcache_wb_buffer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             evict_en = 1'b0;
    logic [31:0]      evict_addr = '0;
    logic [63:0]      evict_data = '0;
    logic             lookup_en = 1'b0;
    logic [31:0]      lookup_addr = '0;
    logic             mem_grant = 1'b0;
    logic [TAG_W-1:0] mem2wb_response = '0;
    logic [1:0]       wb2mem_command;
    logic [31:0]      wb2mem_addr;
    logic [63:0]      wb2mem_data;
    logic             wb_full;
    logic             wb_empty;
    logic             lookup_hit;
    logic [63:0]      lookup_data;
    logic             overflow_err;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf = 1'b0;

    dcache_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .evict_en        (evict_en),
        .evict_addr      (evict_addr),
        .evict_data      (evict_data),
        .lookup_en       (lookup_en),
        .lookup_addr     (lookup_addr),
        .mem_grant       (mem_grant),
        .mem2wb_response (mem2wb_response),
        .wb2mem_command  (wb2mem_command),
        .wb2mem_addr     (wb2mem_addr),
        .wb2mem_data     (wb2mem_data),
        .wb_full         (wb_full),
        .wb_empty        (wb_empty),
        .lookup_hit      (lookup_hit),
        .lookup_data     (lookup_data),
        .overflow_err    (overflow_err)
    );

    always #5 clock = ~clock;

    // Advance one clock edge and apply the buffer's rules to the model.
    task automatic cyc();
        bit p, u;
        @(posedge clock);
        p = (mq.size() > 0) && mem_grant && (mem2wb_response != '0);
        u = evict_en && ((mq.size() < DEPTH) || p);
        if (evict_en && !u) m_ovf = 1'b1;
        if (p) void'(mq.pop_front());
        if (u) mq.push_back('{evict_addr, evict_data});
        #1;
    endtask

    task automatic idle_inputs();
        evict_en        = 1'b0;
        evict_addr      = '0;
        evict_data      = '0;
        lookup_en       = 1'b0;
        lookup_addr     = '0;
        mem_grant       = 1'b0;
        mem2wb_response = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #2;
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        #3;
        total++; if (wb_empty !== 1'b1) $display("FAIL reset_empty act=%b exp=1", wb_empty); else passed++;
        total++; if (wb_full !== 1'b0) $display("FAIL reset_full act=%b exp=0", wb_full); else passed++;
        total++; if (wb2mem_command !== 2'd0) $display("FAIL reset_cmd act=%0d exp=0", wb2mem_command); else passed++;
        total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf act=%b exp=0", overflow_err); else passed++;
        total++; if (wb2mem_addr !== 32'h0) $display("FAIL reset_addr act=%h exp=0", wb2mem_addr); else passed++;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_single_push();
        do_reset();
        mem_grant  = 1'b1;
        evict_en   = 1'b1;
        evict_addr = 32'h0000_1008;
        evict_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        total++; if (wb_empty !== 1'b1) $display("FAIL sp_empty_before act=%b exp=1", wb_empty); else passed++;
        total++; if (wb2mem_command !== 2'd0) $display("FAIL sp_cmd_idle act=%0d exp=0", wb2mem_command); else passed++;
        cyc();
        evict_en = 1'b0;
        #1;
        total++; if (wb_empty !== 1'b0) $display("FAIL sp_empty_after act=%b exp=0", wb_empty); else passed++;
        total++; if (wb2mem_command !== 2'd2) $display("FAIL sp_cmd act=%0d exp=2", wb2mem_command); else passed++;
        total++; if (wb2mem_addr !== 32'h0000_1008) $display("FAIL sp_addr act=%h exp=00001008", wb2mem_addr); else passed++;
        total++; if (wb2mem_data !== 64'hDEAD_BEEF_0000_0001) $display("FAIL sp_data act=%h exp=deadbeef00000001", wb2mem_data); else passed++;
        mem2wb_response = 4'd3;
        cyc();
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb_empty !== 1'b1) $display("FAIL sp_empty_drained act=%b exp=1", wb_empty); else passed++;
        total++; if (wb2mem_command !== 2'd0) $display("FAIL sp_cmd_drained act=%0d exp=0", wb2mem_command); else passed++;
    endtask

    task automatic test_retry();
        do_reset();
        evict_en   = 1'b1;
        evict_addr = 32'h0000_2000;
        evict_data = 64'h1111_2222_3333_4444;
        cyc();
        evict_addr = 32'h0000_2008;
        evict_data = 64'h5555_6666_7777_8888;
        mem_grant  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem2wb_response = (k == 3) ? 4'd5 : 4'd0;
            #1;
            total++; if (wb2mem_command !== 2'd2) $display("FAIL retry_cmd%0d act=%0d exp=2", k, wb2mem_command); else passed++;
            total++; if (wb2mem_addr !== 32'h0000_2000) $display("FAIL retry_addr%0d act=%h exp=00002000", k, wb2mem_addr); else passed++;
            cyc();
            evict_en = 1'b0;
        end
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb2mem_addr !== 32'h0000_2008) $display("FAIL retry_next_addr act=%h exp=00002008", wb2mem_addr); else passed++;
        total++; if (wb2mem_data !== 64'h5555_6666_7777_8888) $display("FAIL retry_next_data act=%h exp=5555666677778888", wb2mem_data); else passed++;
        mem2wb_response = 4'd1;
        cyc();
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb_empty !== 1'b1) $display("FAIL retry_empty act=%b exp=1", wb_empty); else passed++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        evict_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            evict_addr = 32'h100 + 32'(k * 8);
            evict_data = {32'hF000_0000, 32'(k)};
            if (k == 4) begin
                #1;
                total++; if (wb_full !== 1'b1) $display("FAIL fill_full act=%b exp=1", wb_full); else passed++;
            end
            cyc();
        end
        evict_en = 1'b0;
        #1;
        total++; if (overflow_err !== 1'b1) $display("FAIL fill_ovf act=%b exp=1", overflow_err); else passed++;
        total++; if (wb_full !== 1'b1) $display("FAIL fill_full_after act=%b exp=1", wb_full); else passed++;
        mem_grant       = 1'b1;
        mem2wb_response = 4'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (wb2mem_addr !== 32'h100 + 32'(k * 8)) $display("FAIL fill_drain%0d act=%h exp=%h", k, wb2mem_addr, 32'h100 + 32'(k * 8)); else passed++;
            cyc();
        end
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb_empty !== 1'b1) $display("FAIL fill_empty act=%b exp=1", wb_empty); else passed++;
        total++; if (wb2mem_command !== 2'd0) $display("FAIL fill_cmd_end act=%0d exp=0", wb2mem_command); else passed++;
        total++; if (overflow_err !== 1'b1) $display("FAIL fill_ovf_sticky act=%b exp=1", overflow_err); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_a [4];
        exp_a = '{32'h108, 32'h110, 32'h118, 32'h200};
        do_reset();
        evict_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            evict_addr = 32'h100 + 32'(k * 8);
            evict_data = 64'(k);
            cyc();
        end
        evict_addr      = 32'h200;
        evict_data      = 64'hABCD;
        mem_grant       = 1'b1;
        mem2wb_response = 4'd2;
        cyc();
        evict_en = 1'b0;
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb_full !== 1'b1) $display("FAIL fpp_full act=%b exp=1", wb_full); else passed++;
        total++; if (overflow_err !== 1'b0) $display("FAIL fpp_ovf act=%b exp=0", overflow_err); else passed++;
        mem2wb_response = 4'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (wb2mem_addr !== exp_a[k]) $display("FAIL fpp_drain%0d act=%h exp=%h", k, wb2mem_addr, exp_a[k]); else passed++;
            cyc();
        end
        mem2wb_response = 4'd0;
        #1;
        total++; if (wb_empty !== 1'b1) $display("FAIL fpp_empty act=%b exp=1", wb_empty); else passed++;
    endtask

    task automatic test_lookup();
        do_reset();
        evict_en   = 1'b1;
        evict_addr = 32'h300;
        evict_data = 64'hAAAA_AAAA_AAAA_AAAA;
        cyc();
        evict_data = 64'hBBBB_BBBB_BBBB_BBBB;
        cyc();
        evict_en    = 1'b0;
        lookup_en   = 1'b1;
        lookup_addr = 32'h304;
        #1;
        total++; if (lookup_hit !== 1'b1) $display("FAIL lk_hit act=%b exp=1", lookup_hit); else passed++;
        total++; if (lookup_data !== 64'hBBBB_BBBB_BBBB_BBBB) $display("FAIL lk_young act=%h exp=bbbbbbbbbbbbbbbb", lookup_data); else passed++;
        evict_en   = 1'b1;
        evict_data = 64'hCCCC_CCCC_CCCC_CCCC;
        #1;
        total++; if (lookup_data !== 64'hCCCC_CCCC_CCCC_CCCC) $display("FAIL lk_bypass act=%h exp=cccccccccccccccc", lookup_data); else passed++;
        evict_en    = 1'b0;
        lookup_addr = 32'h400;
        #1;
        total++; if (lookup_hit !== 1'b0) $display("FAIL lk_miss_hit act=%b exp=0", lookup_hit); else passed++;
        total++; if (lookup_data !== 64'h0) $display("FAIL lk_miss_data act=%h exp=0", lookup_data); else passed++;
        lookup_en   = 1'b0;
        lookup_addr = 32'h300;
        #1;
        total++; if (lookup_hit !== 1'b0) $display("FAIL lk_disabled act=%b exp=0", lookup_hit); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        mem_grant  = 1'b1;
        evict_en   = 1'b1;
        evict_addr = 32'h700;
        evict_data = 64'h7777;
        cyc();
        evict_en = 1'b0;
        #1;
        total++; if (wb2mem_command !== 2'd2) $display("FAIL rmd_cmd_before act=%0d exp=2", wb2mem_command); else passed++;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        total++; if (wb2mem_command !== 2'd0) $display("FAIL rmd_cmd_async act=%0d exp=0", wb2mem_command); else passed++;
        total++; if (wb2mem_addr !== 32'h0) $display("FAIL rmd_addr_async act=%h exp=0", wb2mem_addr); else passed++;
        total++; if (wb_empty !== 1'b1) $display("FAIL rmd_empty_async act=%b exp=1", wb_empty); else passed++;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            total++; if (wb2mem_command !== 2'd0) $display("FAIL rmd_cmd_after%0d act=%0d exp=0", k, wb2mem_command); else passed++;
            total++; if (wb_empty !== 1'b1) $display("FAIL rmd_empty_after%0d act=%b exp=1", k, wb_empty); else passed++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic        e_hit;
        logic [63:0] e_ld;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            evict_en        = ($urandom_range(0, 99) < 45);
            evict_addr      = 32'h5000 + {26'(0), 3'($urandom_range(0, 7)), 3'b000};
            evict_data      = {$urandom, $urandom};
            lookup_en       = ($urandom_range(0, 3) != 0);
            lookup_addr     = 32'h5000 + {26'(0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            mem_grant       = ($urandom_range(0, 99) < 60);
            mem2wb_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            #1;
            e_cmd  = (mq.size() > 0 && mem_grant) ? 2'd2 : 2'd0;
            e_addr = (e_cmd == 2'd2) ? mq[0].a : 32'h0;
            e_data = (e_cmd == 2'd2) ? mq[0].d : 64'h0;
            e_hit  = 1'b0;
            e_ld   = 64'h0;
            if (lookup_en) begin
                foreach (mq[k]) begin
                    if (mq[k].a[31:3] == lookup_addr[31:3]) begin
                        e_hit = 1'b1;
                        e_ld  = mq[k].d;
                    end
                end
                if (evict_en && evict_addr[31:3] == lookup_addr[31:3]) begin
                    e_hit = 1'b1;
                    e_ld  = evict_data;
                end
            end
            total++; if (wb2mem_command !== e_cmd) $display("FAIL rnd_cmd@%0d act=%0d exp=%0d", n, wb2mem_command, e_cmd); else passed++;
            total++; if (wb2mem_addr !== e_addr) $display("FAIL rnd_addr@%0d act=%h exp=%h", n, wb2mem_addr, e_addr); else passed++;
            total++; if (wb2mem_data !== e_data) $display("FAIL rnd_data@%0d act=%h exp=%h", n, wb2mem_data, e_data); else passed++;
            total++; if (wb_full !== (mq.size() == DEPTH)) $display("FAIL rnd_full@%0d act=%b exp=%b", n, wb_full, mq.size() == DEPTH); else passed++;
            total++; if (wb_empty !== (mq.size() == 0)) $display("FAIL rnd_empty@%0d act=%b exp=%b", n, wb_empty, mq.size() == 0); else passed++;
            total++; if (overflow_err !== m_ovf) $display("FAIL rnd_ovf@%0d act=%b exp=%b", n, overflow_err, m_ovf); else passed++;
            total++; if (lookup_hit !== e_hit) $display("FAIL rnd_hit@%0d act=%b exp=%b", n, lookup_hit, e_hit); else passed++;
            total++; if (lookup_data !== e_ld) $display("FAIL rnd_ldata@%0d act=%h exp=%h", n, lookup_data, e_ld); else passed++;
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_retry();
        test_fill_overflow();
        test_full_push_pop();
        test_lookup();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
